regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of 2, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 1, number of write ports (1..2).
REQ-005 SHALL have parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port stall, input, 1, holds all read outputs when high.
REQ-009 SHALL have port rs_addr, input, NRD*AW, packed read addresses; port i at [i*AW +: AW].
REQ-010 SHALL have port rs_data, output, NRD*XLEN, registered read data per port.
REQ-011 SHALL have port rs_busy, output, NRD, registered scoreboard-busy flag per read port.
REQ-012 SHALL have port wr_en, input, NWR, write enable per write port.
REQ-013 SHALL have port wr_addr, input, NWR*AW, write addresses.
REQ-014 SHALL have port wr_data, input, NWR*XLEN, write data.
REQ-015 SHALL have port mark_en, input, 1, marks register mark_addr busy (pending producer).
REQ-016 SHALL have port mark_addr, input, AW, register to mark busy.

Function
REQ-017 SHALL treat register 0 as hardwired zero: writes and marks to 0 ignored; reads of 0 return data 0 and busy 0.
REQ-018 SHALL write wr_data[j] to wr_addr[j] at the clock edge when wr_en[j]=1 and wr_addr[j]!=0.
REQ-019 SHALL resolve two write ports to one address in one cycle: higher port index wins.
REQ-020 SHALL produce rs_data/rs_busy with 1-cycle latency: values sampled at edge N appear after edge N.
REQ-021 SHALL, with stall=1, hold rs_data and rs_busy unchanged; writes and marks still update state.
REQ-022 SHALL, with BYPASS=1, return the winning same-cycle write data for a matching nonzero read address (forwarding); with BYPASS=0 return the pre-write contents.
REQ-023 SHALL clear a register's busy bit on any enabled nonzero write to it.
REQ-024 SHALL set a register's busy bit on mark_en; a mark and a write to the same register in one cycle leave it busy (mark wins).
REQ-025 SHALL compute rs_busy from next-state busy when BYPASS=1 (same-cycle write clears, same-cycle mark sets), from current busy when BYPASS=0.
REQ-026 SHALL handle all NRD ports independently; identical addresses on several ports return identical values.

Reset
REQ-027 SHALL on reset=0 immediately clear all registers, all busy bits, rs_data and rs_busy to 0, independent of clk.
REQ-028 SHALL ignore wr_en, mark_en and stall while reset=0; first update occurs on the first rising edge after release.
REQ-029 SHALL discard any write or mark coinciding with reset assertion mid-operation.

Structure
REQ-030 SHALL take XLEN, NREGS defaults and AW computation from shared package rf_pkg, with an rf_addr_t typedef.
REQ-031 SHALL implement busy tracking in sub-module rf_scoreboard (NREGS busy bits, mark/clear inputs, combinational next-state lookup per read port).
REQ-032 SHALL use no latches and no combinational path from inputs to rs_data/rs_busy.

Verification
REQ-033 SHALL cover: write x5=0xDEADBEEF, next cycle read x5 on port 0 -> rs_data0=0xDEADBEEF one cycle later.
REQ-034 SHALL cover: write x0=0x1234 and mark x0, read x0 -> rs_data=0, rs_busy=0.
REQ-035 SHALL cover: same-cycle write x7=0xA5A5A5A5 and read x7, BYPASS=1 -> 0xA5A5A5A5; BYPASS=0 -> old value 0.
REQ-036 SHALL cover: NWR=2, both ports write x3 (0x11, 0x22) -> x3 reads 0x22.
REQ-037 SHALL cover: mark x9, read -> busy=1; write x9=0x5 with stall=1 -> outputs held; release stall -> data 0x5, busy 0; mark+write x9 together -> busy=1.
REQ-038 SHALL cover: write x4=0xFF, assert reset mid-cycle -> rs_data and busy 0 before next edge; read x4 after release -> 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file defaults and address type, imported by the regfile_mp slice.
// The address width follows from the register count so both change together.
package rf_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] rf_addr_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between a pipeline front end (master) and the multi-port register file (slave).
interface regfile_mp_if
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(NREGS);

    logic                stall;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                mark_en;
    logic [AW-1:0]       mark_addr;

    modport master (
        output stall, rs_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr,
        input  rs_data, rs_busy
    );

    modport slave (
        input  stall, rs_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr,
        output rs_data, rs_busy
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per register, set by a mark and cleared by writes.
// Exposes both current and next-state busy per read port so the parent can choose forwarding or not.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mark_en,
    input  logic [AW-1:0]     mark_addr,
    input  logic [NWR-1:0]    clr_en,
    input  logic [NWR*AW-1:0] clr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    busy_cur,
    output logic [NRD-1:0]    busy_nxt
);
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears are applied before the mark so a mark and write to one register leave it busy.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (clr_en[j]) begin
                busy_d[clr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (mark_en) begin
            busy_d[mark_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busy_cur = '0;
        busy_nxt = '0;
        for (int i = 0; i < NRD; i++) begin
            busy_cur[i] = busy_q[rd_addr[i*AW +: AW]];
            busy_nxt[i] = busy_d[rd_addr[i*AW +: AW]];
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, optional write-to-read forwarding,
// registered read ports with stall hold, and a busy scoreboard for pending producers.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        reset,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs [NREGS];
    logic [NWR-1:0]      wr_live;
    logic [NRD-1:0]      busy_cur;
    logic [NRD-1:0]      busy_nxt;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NRD*XLEN-1:0] rs_data_q;
    logic [NRD-1:0]      rs_busy_q;

    always_comb begin
        wr_live = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_live[j] = bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != '0);
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .mark_en   (bus.mark_en),
        .mark_addr (bus.mark_addr),
        .clr_en    (wr_live),
        .clr_addr  (bus.wr_addr),
        .rd_addr   (bus.rs_addr),
        .busy_cur  (busy_cur),
        .busy_nxt  (busy_nxt)
    );

    // Ascending port order with non-blocking updates lets the highest write port win a collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_live[j]) begin
                    regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*XLEN +: XLEN] = regs[bus.rs_addr[i*AW +: AW]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_live[j] && (bus.wr_addr[j*AW +: AW] == bus.rs_addr[i*AW +: AW])) begin
                        rd_data[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
                    end
                end
            end
            if (bus.rs_addr[i*AW +: AW] == '0) begin
                rd_data[i*XLEN +: XLEN] = '0;
            end
            rd_busy[i] = (BYPASS != 0) ? busy_nxt[i] : busy_cur[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_data_q <= '0;
            rs_busy_q <= '0;
        end else if (!bus.stall) begin
            rs_data_q <= rd_data;
            rs_busy_q <= rd_busy;
        end
    end

    assign bus.rs_data = rs_data_q;
    assign bus.rs_busy = rs_busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one forwarding instance (dut_a) and one non-forwarding
// instance (dut_b), both with two write ports, driven with identical stimulus.
module tb_regfile_mp;
    import rf_pkg::*;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus_a ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus_b ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_a.stall = 1'b0; bus_a.rs_addr = '0; bus_a.wr_en = '0; bus_a.wr_addr = '0;
        bus_a.wr_data = '0; bus_a.mark_en = 1'b0; bus_a.mark_addr = '0;
        bus_b.stall = 1'b0; bus_b.rs_addr = '0; bus_b.wr_en = '0; bus_b.wr_addr = '0;
        bus_b.wr_data = '0; bus_b.mark_en = 1'b0; bus_b.mark_addr = '0;
    endtask

    task automatic set_write(input int port, input logic en, input rf_addr_t addr, input logic [31:0] data);
        bus_a.wr_en[port] = en; bus_a.wr_addr[port*5 +: 5] = addr; bus_a.wr_data[port*32 +: 32] = data;
        bus_b.wr_en[port] = en; bus_b.wr_addr[port*5 +: 5] = addr; bus_b.wr_data[port*32 +: 32] = data;
    endtask

    task automatic set_read(input int port, input rf_addr_t addr);
        bus_a.rs_addr[port*5 +: 5] = addr;
        bus_b.rs_addr[port*5 +: 5] = addr;
    endtask

    task automatic set_mark(input logic en, input rf_addr_t addr);
        bus_a.mark_en = en; bus_a.mark_addr = addr;
        bus_b.mark_en = en; bus_b.mark_addr = addr;
    endtask

    task automatic set_stall(input logic s);
        bus_a.stall = s;
        bus_b.stall = s;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (bus_a.rs_data !== 64'h0) $display("[TB] FAIL reset_data: got %h expected %h", bus_a.rs_data, 64'h0);
        else n_pass++;
        n_total++;
        if (bus_a.rs_busy !== 2'b00) $display("[TB] FAIL reset_busy: got %b expected %b", bus_a.rs_busy, 2'b00);
        else n_pass++;
        // Writes, marks and reads while reset is held must have no effect.
        set_write(0, 1'b1, 5'd2, 32'hCAFE0000);
        set_mark(1'b1, 5'd2);
        set_read(0, 5'd2);
        step();
        step();
        n_total++;
        if (bus_a.rs_data[31:0] !== 32'h0) $display("[TB] FAIL reset_hold_data: got %h expected %h", bus_a.rs_data[31:0], 32'h0);
        else n_pass++;
        drive_idle();
        #2 reset = 1'b1;
        set_read(0, 5'd2);
        step();
        n_total++;
        if (bus_a.rs_data[31:0] !== 32'h0 || bus_a.rs_busy[0] !== 1'b0)
            $display("[TB] FAIL reset_ignored_write: got %h/%b expected %h/%b", bus_a.rs_data[31:0], bus_a.rs_busy[0], 32'h0, 1'b0);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_write_read();
        set_write(0, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        drive_idle();
        set_read(0, 5'd5);
        set_read(1, 5'd5);
        step();
        n_total++;
        if (bus_a.rs_data[31:0] !== 32'hDEADBEEF) $display("[TB] FAIL write_read_p0: got %h expected %h", bus_a.rs_data[31:0], 32'hDEADBEEF);
        else n_pass++;
        n_total++;
        if (bus_a.rs_data[63:32] !== 32'hDEADBEEF) $display("[TB] FAIL write_read_p1: got %h expected %h", bus_a.rs_data[63:32], 32'hDEADBEEF);
        else n_pass++;
        n_total++;
        if (bus_b.rs_data[31:0] !== 32'hDEADBEEF) $display("[TB] FAIL write_read_nobyp: got %h expected %h", bus_b.rs_data[31:0], 32'hDEADBEEF);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_zero_reg();
        set_write(0, 1'b1, 5'd0, 32'h00001234);
        set_mark(1'b1, 5'd0);
        set_read(0, 5'd0);
        step();
        n_total++;
        if (bus_a.rs_data[31:0] !== 32'h0 || bus_a.rs_busy[0] !== 1'b0)
            $display("[TB] FAIL zero_same_cycle: got %h/%b expected %h/%b", bus_a.rs_data[31:0], bus_a.rs_busy[0], 32'h0, 1'b0);
        else n_pass++;
        set_write(0, 1'b0, 5'd0, 32'h0);
        set_mark(1'b0, 5'd0);
        step();
        n_total++;
        if (bus_a.rs_data[31:0] !== 32'h0 || bus_a.rs_busy[0] !== 1'b0)
            $display("[TB] FAIL zero_after: got %h/%b expected %h/%b", bus_a.rs_data[31:0], bus_a.rs_busy[0], 32'h0, 1'b0);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_bypass();
        set_write(0, 1'b1, 5'd7, 32'hA5A5A5A5);
        set_read(0, 5'd7);
        step();
        n_total++;
        if (bus_a.rs_data[31:0] !== 32'hA5A5A5A5) $display("[TB] FAIL bypass_on: got %h expected %h", bus_a.rs_data[31:0], 32'hA5A5A5A5);
        else n_pass++;
        n_total++;
        if (bus_b.rs_data[31:0] !== 32'h0) $display("[TB] FAIL bypass_off: got %h expected %h", bus_b.rs_data[31:0], 32'h0);
        else n_pass++;
        set_write(0, 1'b0, 5'd0, 32'h0);
        step();
        n_total++;
        if (bus_b.rs_data[31:0] !== 32'hA5A5A5A5) $display("[TB] FAIL bypass_off_later: got %h expected %h", bus_b.rs_data[31:0], 32'hA5A5A5A5);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_dual_write();
        set_write(0, 1'b1, 5'd3, 32'h00000011);
        set_write(1, 1'b1, 5'd3, 32'h00000022);
        set_read(0, 5'd3);
        step();
        n_total++;
        if (bus_a.rs_data[31:0] !== 32'h00000022) $display("[TB] FAIL dual_fwd: got %h expected %h", bus_a.rs_data[31:0], 32'h22);
        else n_pass++;
        set_write(0, 1'b0, 5'd0, 32'h0);
        set_write(1, 1'b0, 5'd0, 32'h0);
        step();
        n_total++;
        if (bus_b.rs_data[31:0] !== 32'h00000022) $display("[TB] FAIL dual_stored: got %h expected %h", bus_b.rs_data[31:0], 32'h22);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_scoreboard();
        set_mark(1'b1, 5'd9);
        set_read(0, 5'd9);
        set_read(1, 5'd5);
        step();
        n_total++;
        if (bus_a.rs_busy[0] !== 1'b1) $display("[TB] FAIL mark_fwd_busy: got %b expected %b", bus_a.rs_busy[0], 1'b1);
        else n_pass++;
        n_total++;
        if (bus_b.rs_busy[0] !== 1'b0) $display("[TB] FAIL mark_cur_busy: got %b expected %b", bus_b.rs_busy[0], 1'b0);
        else n_pass++;
        n_total++;
        if (bus_a.rs_data[63:32] !== 32'hDEADBEEF || bus_a.rs_busy[1] !== 1'b0)
            $display("[TB] FAIL port1_indep: got %h/%b expected %h/%b", bus_a.rs_data[63:32], bus_a.rs_busy[1], 32'hDEADBEEF, 1'b0);
        else n_pass++;
        set_mark(1'b0, 5'd0);
        step();
        n_total++;
        if (bus_b.rs_busy[0] !== 1'b1) $display("[TB] FAIL mark_cur_later: got %b expected %b", bus_b.rs_busy[0], 1'b1);
        else n_pass++;
        set_stall(1'b1);
        set_write(0, 1'b1, 5'd9, 32'h00000005);
        step();
        n_total++;
        if (bus_a.rs_data[31:0] !== 32'h0 || bus_a.rs_busy[0] !== 1'b1)
            $display("[TB] FAIL stall_hold: got %h/%b expected %h/%b", bus_a.rs_data[31:0], bus_a.rs_busy[0], 32'h0, 1'b1);
        else n_pass++;
        set_stall(1'b0);
        set_write(0, 1'b0, 5'd0, 32'h0);
        step();
        n_total++;
        if (bus_b.rs_data[31:0] !== 32'h5 || bus_b.rs_busy[0] !== 1'b0)
            $display("[TB] FAIL stall_release: got %h/%b expected %h/%b", bus_b.rs_data[31:0], bus_b.rs_busy[0], 32'h5, 1'b0);
        else n_pass++;
        set_write(0, 1'b1, 5'd9, 32'h00000006);
        set_mark(1'b1, 5'd9);
        step();
        n_total++;
        if (bus_a.rs_data[31:0] !== 32'h6 || bus_a.rs_busy[0] !== 1'b1)
            $display("[TB] FAIL mark_write_fwd: got %h/%b expected %h/%b", bus_a.rs_data[31:0], bus_a.rs_busy[0], 32'h6, 1'b1);
        else n_pass++;
        n_total++;
        if (bus_b.rs_data[31:0] !== 32'h5 || bus_b.rs_busy[0] !== 1'b0)
            $display("[TB] FAIL mark_write_cur: got %h/%b expected %h/%b", bus_b.rs_data[31:0], bus_b.rs_busy[0], 32'h5, 1'b0);
        else n_pass++;
        set_write(0, 1'b0, 5'd0, 32'h0);
        set_mark(1'b0, 5'd0);
        step();
        n_total++;
        if (bus_b.rs_data[31:0] !== 32'h6 || bus_b.rs_busy[0] !== 1'b1)
            $display("[TB] FAIL mark_wins: got %h/%b expected %h/%b", bus_b.rs_data[31:0], bus_b.rs_busy[0], 32'h6, 1'b1);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_reset_mid();
        set_write(0, 1'b1, 5'd4, 32'h000000FF);
        step();
        set_write(0, 1'b0, 5'd0, 32'h0);
        set_read(0, 5'd4);
        set_read(1, 5'd9);
        step();
        n_total++;
        if (bus_a.rs_data[31:0] !== 32'hFF || bus_a.rs_busy[1] !== 1'b1)
            $display("[TB] FAIL pre_reset: got %h/%b expected %h/%b", bus_a.rs_data[31:0], bus_a.rs_busy[1], 32'hFF, 1'b1);
        else n_pass++;
        #2 reset = 1'b0;
        set_write(0, 1'b1, 5'd4, 32'h00000077);
        #1;
        n_total++;
        if (bus_a.rs_data !== 64'h0 || bus_a.rs_busy !== 2'b00)
            $display("[TB] FAIL async_clear: got %h/%b expected %h/%b", bus_a.rs_data, bus_a.rs_busy, 64'h0, 2'b00);
        else n_pass++;
        step();
        set_write(0, 1'b0, 5'd0, 32'h0);
        #2 reset = 1'b1;
        step();
        n_total++;
        if (bus_a.rs_data[31:0] !== 32'h0 || bus_a.rs_busy[1] !== 1'b0)
            $display("[TB] FAIL post_reset: got %h/%b expected %h/%b", bus_a.rs_data[31:0], bus_a.rs_busy[1], 32'h0, 1'b0);
        else n_pass++;
        drive_idle();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
